shadow_reg_bank: RTL and testbench
==================================

# shadow_reg_bank

Parametrised, clocked successor to our single-bit D latch: a bank of CHANNELS registers, each WIDTH bits, with a double-buffered write path. Writes land in per-channel shadow registers and are tracked by pending bits. A single commit transfers every shadow value to the active outputs in the same cycle, so downstream logic never sees a partially updated configuration. The block sits between a control/config writer and datapath blocks that consume static configuration words.

## Interface
Parameters:
- WIDTH, 8, bits per channel (≥1)
- CHANNELS, 4, number of channels (≥1)
- SEL_W, 2, channel-select width; must satisfy 2^SEL_W ≥ CHANNELS

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  reset; asynchronous, active-low
- wr_en  input  1  write strobe for the shadow register selected by wr_sel
- wr_sel  input  SEL_W  target channel index
- wr_data  input  WIDTH  write data
- commit  input  1  request to copy all shadow registers to the active registers
- q  output  CHANNELS*WIDTH  active values; channel i occupies bits [i*WIDTH +: WIDTH]
- pending  output  CHANNELS  bit i set when shadow i has been written since the last executed commit
- commit_done  output  1  one-cycle pulse, one cycle after a commit executes
- hold  input  1  present only with REG_BANK_HOLD_EN; defers commits while high

## Operation
- Reset (rst_n low, asynchronous): shadow, q, pending, commit_done, and deferred-commit flag all clear to 0 immediately; they stay 0 while rst_n is low.
- Write: wr_en=1 with wr_sel < CHANNELS → shadow[wr_sel] ← wr_data and pending[wr_sel] ← 1 at the edge. q is unchanged.
- Out-of-range write: wr_sel ≥ CHANNELS → the write is ignored; no state changes.
- Commit execution: every channel's q ← shadow (full copy); pending ← 0; commit_done = 1 on the following cycle.
- Empty commit (pending = 0): still executes. q is unchanged, since shadow already equals active. commit_done still pulses.
- Write and commit in the same cycle: the commit copies shadow values from before the write. The write lands in shadow. That channel's pending bit ends at 1; all other pending bits clear.
- Repeated writes to the same channel before a commit: last write wins.
- Back-to-back commits: each executes. commit_done stays high for consecutive cycles.

## Timing
- Write to shadow: 1 cycle. Shadow is not externally visible.
- Commit to q update: q changes at the rising edge where commit is sampled high, so q is visible the cycle after assertion.
- commit_done: registered; high in the same cycle q first shows the new values.
- pending: registered; updates at the same edge as the write or commit.
- No combinational path from any input to q, pending or commit_done.
- Reset deasserting mid-sequence: the first edge with rst_n high behaves as normal operation from the all-zero state. Writes and commits made before reset are lost.

## Configuration
- Macro: REG_BANK_HOLD_EN.
- Defined:
  - The hold port exists.
  - Commit sampled while hold=1 sets a deferred-commit flag instead of executing.
  - The commit executes at the first edge where hold=0, whether from the flag or a fresh commit. It copies the shadow as of that edge, including writes made during hold. The flag then clears.
  - Multiple commits during hold collapse into one execution and one commit_done pulse.
  - Writes and pending tracking are unaffected by hold.
  - Reset clears the flag.
- Undefined: no hold port and no flag; every commit executes immediately as described above.

## Test plan
- Reset check: drive rst_n low mid-cycle after writes → q=0, pending=0 and commit_done=0 without waiting for a clock edge.
- Basic double-buffer: write ch0=0xA5, ch2=0x3C → pending=4'b0101, q=0; commit → next cycle q ch0=0xA5, ch2=0x3C, others 0, pending=0, commit_done pulses once.
- Simultaneous write and commit: shadow ch1=0x11 committed; then write ch1=0x22 with commit in the same cycle → q ch1=0x11, pending=4'b0010; a second commit → q ch1=0x22.
- Out-of-range and empty commit: CHANNELS=3, SEL_W=2, write sel=3 data=0xFF → no pending change; commit → q unchanged, commit_done pulses.
- Hold (REG_BANK_HOLD_EN): hold=1, commit twice, write ch3=0x77 → q unchanged, no commit_done; drop hold → next cycle q ch3=0x77, exactly one commit_done pulse.

Source files
------------

// File: rtl/shadow_reg_bank.sv
// shadow_reg_bank: CHANNELS x WIDTH configuration bank with double-buffered writes.
// Writes land in per-channel shadow registers and set a pending bit. A commit copies
// every shadow value to the active outputs in a single edge.
// Optional feature macro: REG_BANK_HOLD_EN adds a hold input that defers commits.
module shadow_reg_bank #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [SEL_W-1:0]          wr_sel,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit,
`ifdef REG_BANK_HOLD_EN
    input  logic                      hold,
`endif
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       pending,
    output logic                      commit_done
);

    typedef logic [CHANNELS-1:0][WIDTH-1:0] bank_t;

    bank_t               shadow_q, shadow_d;
    bank_t               active_q, active_d;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic                done_q, done_d;
    logic [CHANNELS-1:0] wr_hit_c;
    logic                exec_c;

    // One-hot write target; selects at or beyond CHANNELS shift out and hit nothing
    assign wr_hit_c = wr_en ? (CHANNELS'(1) << wr_sel) : '0;

`ifdef REG_BANK_HOLD_EN
    logic defer_q, defer_d;

    // Commits seen during hold collapse into one deferred request
    always_comb begin
        exec_c  = 1'b0;
        defer_d = 1'b0;
        if (hold) begin
            defer_d = defer_q | commit;
        end else begin
            exec_c  = defer_q | commit;
        end
    end

    // Deferred-commit flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            defer_q <= 1'b0;
        end else begin
            defer_q <= defer_d;
        end
    end
`else
    assign exec_c = commit;
`endif

    // Per-channel shadow update: last write wins
    for (genvar g = 0; g < CHANNELS; g++) begin : g_shadow
        assign shadow_d[g] = wr_hit_c[g] ? wr_data : shadow_q[g];
    end

    // Commit copies the pre-write shadow; a same-cycle write stays pending
    always_comb begin
        active_d  = active_q;
        pending_d = pending_q | wr_hit_c;
        done_d    = 1'b0;
        if (exec_c) begin
            active_d  = shadow_q;
            pending_d = wr_hit_c;
            done_d    = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= '0;
            done_q    <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    assign q           = active_q;
    assign pending     = pending_q;
    assign commit_done = done_q;

endmodule

// File: tb/tb_shadow_reg_bank.sv
// Bench for shadow_reg_bank: a 4-channel and a 3-channel instance share one stimulus
// stream and are compared every cycle against an array-based reference model.
module tb_shadow_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        commit;
    logic        hold_b;
    logic [31:0] q4;
    logic [3:0]  pend4;
    logic        done4;
    logic [23:0] q3;
    logic [2:0]  pend3;
    logic        done3;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    shadow_reg_bank #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .commit(commit),
`ifdef REG_BANK_HOLD_EN
        .hold(hold_b),
`endif
        .q(q4), .pending(pend4), .commit_done(done4)
    );

    shadow_reg_bank #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .commit(commit),
`ifdef REG_BANK_HOLD_EN
        .hold(hold_b),
`endif
        .q(q3), .pending(pend3), .commit_done(done3)
    );

    // Reference model: index 0 models the 4-channel bank, index 1 the 3-channel bank
    int unsigned nch [2] = '{4, 3};
    logic [7:0]  m_sh   [2][4];
    logic [7:0]  m_act  [2][4];
    logic        m_pend [2][4];
    logic        m_done [2];
    logic        m_defer[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin
                m_sh[k][c]   = 8'h00;
                m_act[k][c]  = 8'h00;
                m_pend[k][c] = 1'b0;
            end
            m_done[k]  = 1'b0;
            m_defer[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic run;
            if (hold_b) begin
                run        = 1'b0;
                m_defer[k] = m_defer[k] | commit;
            end else begin
                run        = commit | m_defer[k];
                m_defer[k] = 1'b0;
            end
            if (run) begin
                for (int c = 0; c < 4; c++) begin
                    m_act[k][c]  = m_sh[k][c];
                    m_pend[k][c] = 1'b0;
                end
            end
            m_done[k] = run;
            if (wr_en && (int'(wr_sel) < int'(nch[k]))) begin
                m_sh[k][wr_sel]   = wr_data;
                m_pend[k][wr_sel] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] eq4, eq3, ep4, ep3;
        eq4 = '0; eq3 = '0; ep4 = '0; ep3 = '0;
        for (int c = 0; c < 4; c++) begin
            eq4[c*8 +: 8] = m_act[0][c];
            ep4[c]        = m_pend[0][c];
        end
        for (int c = 0; c < 3; c++) begin
            eq3[c*8 +: 8] = m_act[1][c];
            ep3[c]        = m_pend[1][c];
        end
        chk({tag, ".q4"},    q4,               eq4);
        chk({tag, ".pend4"}, {28'h0, pend4},   ep4);
        chk({tag, ".done4"}, {31'h0, done4},   {31'h0, m_done[0]});
        chk({tag, ".q3"},    {8'h0, q3},       eq3);
        chk({tag, ".pend3"}, {29'h0, pend3},   ep3);
        chk({tag, ".done3"}, {31'h0, done3},   {31'h0, m_done[1]});
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after
    task automatic cyc(input string tag, input logic en, input logic [1:0] sel,
                       input logic [7:0] data, input logic cm);
        wr_en   = en;
        wr_sel  = sel;
        wr_data = data;
        commit  = cm;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [23:0] q3_before;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 2'd0;
        wr_data = 8'h00;
        commit  = 1'b0;
        hold_b  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Basic double-buffer
        cyc("wr0", 1'b1, 2'd0, 8'hA5, 1'b0);
        cyc("wr2", 1'b1, 2'd2, 8'h3C, 1'b0);
        chk("basic.pend", {28'h0, pend4}, 32'h5);
        chk("basic.q_pre", q4, 32'h0);
        cyc("commit1", 1'b0, 2'd0, 8'h00, 1'b1);
        chk("basic.q", q4, 32'h003C_00A5);
        chk("basic.done", {31'h0, done4}, 32'h1);
        cyc("idle1", 1'b0, 2'd0, 8'h00, 1'b0);
        chk("basic.done_low", {31'h0, done4}, 32'h0);

        // Write and commit in the same cycle
        cyc("wr1", 1'b1, 2'd1, 8'h11, 1'b0);
        cyc("commit2", 1'b0, 2'd0, 8'h00, 1'b1);
        cyc("wr1_commit", 1'b1, 2'd1, 8'h22, 1'b1);
        chk("simul.q1", {24'h0, q4[15:8]}, 32'h11);
        chk("simul.pend", {28'h0, pend4}, 32'h2);
        cyc("commit3", 1'b0, 2'd0, 8'h00, 1'b1);
        chk("simul.q1_new", {24'h0, q4[15:8]}, 32'h22);
        chk("b2b.done", {31'h0, done4}, 32'h1);

        // Out-of-range write on the 3-channel bank, then an empty commit there
        cyc("wr3", 1'b1, 2'd3, 8'hFF, 1'b0);
        chk("oor.pend3", {29'h0, pend3}, 32'h0);
        q3_before = q3;
        cyc("commit4", 1'b0, 2'd0, 8'h00, 1'b1);
        chk("oor.q3_same", {8'h0, q3}, {8'h0, q3_before});
        chk("oor.done3", {31'h0, done3}, 32'h1);
        chk("oor.q4_ch3", {24'h0, q4[31:24]}, 32'hFF);
        cyc("idle2", 1'b0, 2'd0, 8'h00, 1'b0);

`ifdef REG_BANK_HOLD_EN
        // Commits under hold collapse into one deferred execution
        hold_b = 1'b1;
        cyc("hold_c1", 1'b0, 2'd0, 8'h00, 1'b1);
        cyc("hold_c2", 1'b0, 2'd0, 8'h00, 1'b1);
        cyc("hold_wr", 1'b1, 2'd3, 8'h77, 1'b0);
        chk("hold.q_same", {24'h0, q4[31:24]}, 32'hFF);
        chk("hold.no_done", {31'h0, done4}, 32'h0);
        hold_b = 1'b0;
        cyc("hold_rel", 1'b0, 2'd0, 8'h00, 1'b0);
        chk("hold.q_new", {24'h0, q4[31:24]}, 32'h77);
        chk("hold.done", {31'h0, done4}, 32'h1);
        cyc("hold_after", 1'b0, 2'd0, 8'h00, 1'b0);
        chk("hold.single_pulse", {31'h0, done4}, 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
`ifdef REG_BANK_HOLD_EN
            hold_b = ($urandom_range(0, 3) == 0);
`endif
            cyc("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                8'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-cycle, checked before any edge
        hold_b = 1'b0;
        cyc("pre_rst_wr", 1'b1, 2'd1, 8'h5A, 1'b1);
        cyc("pre_rst_wr2", 1'b1, 2'd0, 8'hC3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.q4", q4, 32'h0);
        chk("async_rst.pend4", {28'h0, pend4}, 32'h0);
        chk("async_rst.done4", {31'h0, done4}, 32'h0);
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("post_rst_commit", 1'b0, 2'd0, 8'h00, 1'b1);
        chk("post_rst.q4", q4, 32'h0);
        cyc("post_rst_wr", 1'b1, 2'd2, 8'h9E, 1'b0);
        cyc("post_rst_commit2", 1'b0, 2'd0, 8'h00, 1'b1);
        chk("post_rst.q4_ch2", q4, 32'h009E_0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
